// File: rtl/i2c_reg_ctrl_if.sv
// Byte-event and register-file signals between the I2C bit layer, the
// transaction controller and the register file.
interface i2c_reg_ctrl_if;
    logic       start_i;
    logic       stop_i;
    logic       byte_valid_i;
    logic [7:0] byte_i;
    logic       tx_req_i;
    logic       nack_i;
    logic [7:0] reg_rdata_i;
    logic       ack_o;
    logic [7:0] tx_byte_o;
    logic       tx_valid_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       busy_o;

    modport slave (
        input  start_i, stop_i, byte_valid_i, byte_i, tx_req_i, nack_i, reg_rdata_i,
        output ack_o, tx_byte_o, tx_valid_o, reg_addr_o, reg_wdata_o, reg_we_o, busy_o
    );

    modport master (
        output start_i, stop_i, byte_valid_i, byte_i, tx_req_i, nack_i, reg_rdata_i,
        input  ack_o, tx_byte_o, tx_valid_o, reg_addr_o, reg_wdata_o, reg_we_o, busy_o
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// I2C byte-level transaction controller: address decode, register pointer,
// write strobes, read fetches and ACK decisions for the bit layer.
module i2c_reg_ctrl #(
    parameter logic       ADDR_HI  = 1'b1,
    parameter logic [7:0] LED_LAST = 8'd69,
    parameter logic [7:0] PRE_BASE = 8'd250
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [5:0]    address_i,
    input  logic          ai_i,
    i2c_reg_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, PTR, WRITE, READ, IGNORE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       ack_q, ack_d;
    logic       we_q, we_d;
    logic       tx_valid_q, tx_valid_d;
    logic       adv_q, adv_d;

    function automatic logic implemented(input logic [7:0] a);
        return (a <= LED_LAST) || (a >= PRE_BASE);
    endfunction

    // The gap between the two banks is walked linearly; only the bank ends wrap.
    function automatic logic [7:0] next_ptr(input logic [7:0] a);
        if (a == LED_LAST) return 8'd0;
        if (a == 8'd255)   return PRE_BASE;
        return a + 8'd1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        wdata_d    = wdata_q;
        tx_byte_d  = tx_byte_q;
        ack_d      = ack_q;
        we_d       = 1'b0;
        tx_valid_d = 1'b0;
        adv_d      = 1'b0;

        // A write's pointer advance lands one edge after its strobe.
        if (adv_q) ptr_d = next_ptr(ptr_q);

        if (bus.stop_i) begin
            state_d = IDLE;
            ack_d   = 1'b0;
        end else if (bus.start_i) begin
            state_d = ADDR;
            ack_d   = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: if (bus.byte_valid_i) begin
                    if (bus.byte_i[7:1] == {ADDR_HI, address_i}) begin
                        ack_d   = 1'b1;
                        state_d = bus.byte_i[0] ? READ : PTR;
                    end else begin
                        ack_d   = 1'b0;
                        state_d = IGNORE;
                    end
                end
                PTR: if (bus.byte_valid_i) begin
                    ptr_d   = bus.byte_i;
                    ack_d   = 1'b1;
                    state_d = WRITE;
                end
                WRITE: if (bus.byte_valid_i) begin
                    ack_d   = 1'b1;
                    wdata_d = bus.byte_i;
                    we_d    = implemented(ptr_q);
                    adv_d   = ai_i;
                end
                READ: begin
                    if (bus.byte_valid_i) ack_d = 1'b0;
                    if (bus.nack_i) begin
                        state_d = IGNORE;
                    end else if (bus.tx_req_i) begin
                        tx_byte_d  = implemented(ptr_q) ? bus.reg_rdata_i : 8'h00;
                        tx_valid_d = 1'b1;
                        if (ai_i) ptr_d = next_ptr(ptr_q);
                    end
                end
                default: if (bus.byte_valid_i) ack_d = 1'b0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= 8'd0;
            wdata_q    <= 8'd0;
            tx_byte_q  <= 8'd0;
            ack_q      <= 1'b0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            adv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            tx_byte_q  <= tx_byte_d;
            ack_q      <= ack_d;
            we_q       <= we_d;
            tx_valid_q <= tx_valid_d;
            adv_q      <= adv_d;
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.tx_byte_o   = tx_byte_q;
    assign bus.tx_valid_o  = tx_valid_q;
    assign bus.reg_addr_o  = ptr_q;
    assign bus.reg_wdata_o = wdata_q;
    assign bus.reg_we_o    = we_q;
    assign bus.busy_o      = (state_q == PTR) || (state_q == WRITE) || (state_q == READ);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level model of the device.
module tb_i2c_reg_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [5:0] address_i = 6'd0;
    logic       ai_i = 1'b0;

    i2c_reg_ctrl_if bus();

    i2c_reg_ctrl dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .address_i (address_i),
        .ai_i      (ai_i),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [256];
    assign bus.reg_rdata_i = mem[bus.reg_addr_o];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Transaction-level model: phase 0 = not addressed, 1 = awaiting address,
    // 2 = awaiting pointer, 3 = writing, 4 = reading.
    int         m_ptr = 0;
    int         m_phase = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    function automatic bit impl(input int p);
        return (p <= 69) || (p >= 250);
    endfunction

    function automatic int adv(input int p);
        if (p == 69)  return 0;
        if (p == 255) return 250;
        return p + 1;
    endfunction

    function automatic bit model_byte(input logic [7:0] b);
        bit ack = 1'b0;
        case (m_phase)
            1: if (b[7:1] == {1'b1, address_i}) begin
                   ack = 1'b1;
                   m_phase = b[0] ? 4 : 2;
               end else m_phase = 0;
            2: begin ack = 1'b1; m_ptr = b; m_phase = 3; end
            3: begin
                   ack = 1'b1;
                   if (impl(m_ptr)) exp_wr.push_back({m_ptr[7:0], b});
                   if (ai_i) m_ptr = adv(m_ptr);
               end
            default: ack = 1'b0;
        endcase
        return ack;
    endfunction

    always @(negedge clk_i) begin
        if (bus.reg_we_o === 1'b1) begin
            if (exp_wr.size() == 0) check("we_unexpected", bus.reg_we_o, 0);
            else check("we_addr_data", {bus.reg_addr_o, bus.reg_wdata_o}, exp_wr.pop_front());
        end
        if (bus.tx_valid_o === 1'b1) begin
            if (exp_rd.size() == 0) check("txv_unexpected", bus.tx_valid_o, 0);
            else check("tx_byte", bus.tx_byte_o, exp_rd.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        m_phase = 1;
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        check("ack_clr_start", bus.ack_o, 0);
        tick(3);
    endtask

    task automatic do_stop();
        m_phase = 0;
        bus.stop_i = 1'b1;
        tick(1);
        bus.stop_i = 1'b0;
        check("ack_clr_stop", bus.ack_o, 0);
        check("busy_stop", bus.busy_o, 0);
        tick(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit exp_ack;
        exp_ack = model_byte(b);
        bus.byte_i = b;
        bus.byte_valid_i = 1'b1;
        tick(1);
        bus.byte_valid_i = 1'b0;
        check("ack", bus.ack_o, exp_ack);
        check("busy", bus.busy_o, m_phase >= 2);
        tick(3);
    endtask

    task automatic do_tx_req();
        if (m_phase == 4) begin
            exp_rd.push_back(impl(m_ptr) ? mem[m_ptr] : 8'h00);
            if (ai_i) m_ptr = adv(m_ptr);
        end
        bus.tx_req_i = 1'b1;
        tick(1);
        bus.tx_req_i = 1'b0;
        tick(3);
    endtask

    task automatic do_nack();
        if (m_phase == 4) m_phase = 0;
        bus.nack_i = 1'b1;
        tick(1);
        bus.nack_i = 1'b0;
        check("busy_nack", bus.busy_o, m_phase >= 2);
        tick(3);
    endtask

    task automatic end_txn();
        do_stop();
        check("wr_queue_empty", exp_wr.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("ptr", bus.reg_addr_o, m_ptr);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        do_start();
        send_byte({1'b1, address_i, 1'b0});
        send_byte(p);
        end_txn();
    endtask

    initial begin
        logic [7:0] ptr_pick [9];
        int n;

        bus.start_i = 0; bus.stop_i = 0; bus.byte_valid_i = 0; bus.byte_i = 0;
        bus.tx_req_i = 0; bus.nack_i = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        mem[100] = 8'hA5;

        tick(3);
        check("rst_ack", bus.ack_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_ptr", bus.reg_addr_o, 0);
        check("rst_we", bus.reg_we_o, 0);
        check("rst_txv", bus.tx_valid_o, 0);
        check("rst_wdata", bus.reg_wdata_o, 0);
        check("rst_txbyte", bus.tx_byte_o, 0);
        rst_ni = 1'b1;
        tick(2);

        // Address match, single write.
        address_i = 6'h00; ai_i = 1'b1;
        do_start(); send_byte(8'h80); send_byte(8'h06); send_byte(8'hAB); end_txn();

        // Address mismatch: later bytes ignored.
        address_i = 6'h05;
        do_start(); send_byte(8'h80); send_byte(8'h06); end_txn();

        // Low-bank wrap on writes, high-bank wrap on reads.
        address_i = 6'h00;
        do_start(); send_byte(8'h80); send_byte(8'd68);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); end_txn();
        set_ptr(8'd254);
        do_start(); send_byte(8'h81); do_tx_req(); do_tx_req(); do_nack(); end_txn();

        // Unimplemented address: ACKed write with no strobe, read returns zero.
        set_ptr(8'd100);
        do_start(); send_byte(8'h80); send_byte(8'd100); send_byte(8'h5C); end_txn();
        do_start(); send_byte(8'h81); do_tx_req(); end_txn();

        // No auto-increment: repeated writes hit one register.
        ai_i = 1'b0;
        do_start(); send_byte(8'h80); send_byte(8'd10);
        send_byte(8'h11); send_byte(8'h22); end_txn();

        // Repeated START read, then tx_req after NACK must be silent.
        ai_i = 1'b1;
        do_start(); send_byte(8'h80); send_byte(8'h08);
        do_start(); send_byte(8'h81); do_tx_req(); do_tx_req(); do_nack();
        do_tx_req(); end_txn();

        // Reset coincident with a write byte: no strobe, everything cleared.
        do_start(); send_byte(8'h80); send_byte(8'd30);
        bus.byte_i = 8'h5A; bus.byte_valid_i = 1'b1; rst_ni = 1'b0;
        tick(1);
        bus.byte_valid_i = 1'b0; rst_ni = 1'b1;
        m_ptr = 0; m_phase = 0;
        check("rstw_ack", bus.ack_o, 0);
        check("rstw_busy", bus.busy_o, 0);
        check("rstw_ptr", bus.reg_addr_o, 0);
        check("rstw_wdata", bus.reg_wdata_o, 0);
        check("rstw_txbyte", bus.tx_byte_o, 0);
        tick(3);
        check("rstw_no_we", exp_wr.size(), 0);

        // START wins over a same-cycle byte during WRITE.
        do_start(); send_byte(8'h80); send_byte(8'd40);
        m_phase = 1;
        bus.byte_i = 8'h77; bus.start_i = 1'b1; bus.byte_valid_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0; bus.byte_valid_i = 1'b0;
        check("prio_ack", bus.ack_o, 0);
        tick(3);
        send_byte(8'h81); do_tx_req(); do_nack(); end_txn();

        // Randomized transactions.
        ptr_pick = '{8'd68, 8'd69, 8'd70, 8'd100, 8'd249, 8'd250, 8'd254, 8'd255, 8'd0};
        for (int t = 0; t < 60; t++) begin
            address_i = 6'($urandom);
            ai_i = 1'($urandom);
            do_start();
            if ($urandom_range(0, 9) < 8) send_byte({1'b1, address_i, 1'($urandom)});
            else send_byte(8'($urandom));
            if (m_phase == 2) begin
                n = $urandom_range(0, 8);
                send_byte(n == 8 ? 8'($urandom) : ptr_pick[n]);
                n = $urandom_range(0, 4);
                for (int k = 0; k < n; k++) send_byte(8'($urandom));
            end else if (m_phase == 4) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) do_tx_req();
                if ($urandom_range(0, 1) == 1) do_nack();
            end else begin
                send_byte(8'($urandom));
            end
            end_txn();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Byte-level transaction controller between the I2C bit-layer receiver and the PCA9685-compatible register file. It decodes the address byte against the strap pins and owns the register pointer. It sequences register writes and read-data fetches, and drives ACK/NACK decisions back to the bit layer. All logic runs in the system clock domain; the bit layer delivers synchronized single-cycle event pulses.

## Interface
- ADDR_HI, 1'b1, fixed bit 6 of the 7-bit device address
- LED_LAST, 8'd69, last implemented register of the low bank (0..LED_LAST)
- PRE_BASE, 8'd250, first register of the high bank (PRE_BASE..255)

Ports:
- clk_i  in  1  system clock; everything samples on posedge
- rst_ni  in  1  synchronous, active-low reset
- address_i  in  6  strap pins A5..A0
- ai_i  in  1  MODE1.AI auto-increment enable from the register file
- start_i  in  1  pulse: START or repeated START seen
- stop_i  in  1  pulse: STOP seen
- byte_valid_i  in  1  pulse: byte_i complete (8 bits received)
- byte_i  in  8  received byte, MSB first as transmitted
- tx_req_i  in  1  pulse: bit layer needs next read byte
- nack_i  in  1  pulse: master NACKed a read byte
- reg_rdata_i  in  8  register file combinational read data at reg_addr_o
- ack_o  out  1  1 = drive ACK (SDA low) for the last received byte
- tx_byte_o  out  8  read byte for the bit layer
- tx_valid_o  out  1  pulse: tx_byte_o updated
- reg_addr_o  out  8  register pointer
- reg_wdata_o  out  8  write data
- reg_we_o  out  1  single-cycle write strobe
- busy_o  out  1  device currently addressed (state PTR/WRITE/READ)

## Operation
- States: IDLE, ADDR, PTR, WRITE, READ, IGNORE.
- Reset (rst_ni=0 at posedge) leaves the block in this state:
  - state=IDLE, reg_addr_o=0, reg_wdata_o=0, tx_byte_o=0
  - ack_o=0, reg_we_o=0, tx_valid_o=0, busy_o=0
- Reset mid-transaction drops the transaction with no write strobe.
- Any state + start_i -> ADDR. Any state + stop_i -> IDLE. start_i/stop_i take priority over byte_valid_i, tx_req_i and nack_i in the same cycle.
- ADDR + byte_valid_i:
  - byte_i[7:1] == {ADDR_HI, address_i}:
    - ack_o=1.
    - byte_i[0]=0 -> PTR.
    - byte_i[0]=1 -> READ.
  - Otherwise: ack_o=0 and go to IGNORE.
- PTR + byte_valid_i: reg_addr_o <= byte_i, ack_o=1, go to WRITE. No write strobe.
- WRITE + byte_valid_i:
  - ack_o=1 and reg_wdata_o <= byte_i.
  - reg_we_o=1 only if reg_addr_o is implemented (≤LED_LAST or ≥PRE_BASE); unimplemented addresses are ACKed with no strobe.
  - Pointer then advances if ai_i=1.
- READ + tx_req_i: tx_byte_o <= reg_rdata_i, tx_valid_o=1 for one cycle. Pointer then advances if ai_i=1. Unimplemented addresses return 8'h00.
- READ + nack_i -> IGNORE.
- IGNORE and IDLE: ack_o=0; every byte is ignored.
- Pointer advance rules:
  - LED_LAST -> 0.
  - 255 -> PRE_BASE.
  - Addresses in LED_LAST+1 .. PRE_BASE-1 -> +1.
  - All others -> +1.
- ai_i=0: pointer holds, so repeated writes hit the same register.
- The pointer persists across transactions (a read without a preceding PTR uses the retained value) and is cleared only by reset.

## Timing
- ack_o updates on the posedge after byte_valid_i and holds until the next byte_valid_i, start_i or stop_i. The bit layer samples it no earlier than 2 clk after byte_valid_i.
- reg_we_o, reg_wdata_o and the pre-advance reg_addr_o are valid together in the cycle after byte_valid_i. The pointer advance occurs on the following posedge, so write latency is 1 clk.
- tx_valid_o and tx_byte_o appear 1 clk after tx_req_i; the pointer advances on that same edge.
- The bit layer guarantees at least 4 clk between event pulses; back-to-back pulses need not be handled.
- ack_o clears one cycle after start_i or stop_i.

## Test plan
- Address match: address_i=6'h00, START, byte 8'h80, 8'h06, 8'hAB, STOP -> ack_o=1 three times; one reg_we_o with addr 6, data AB; busy_o falls after STOP.
- Address mismatch: address_i=6'h05, byte 8'h80 -> ack_o=0, state IGNORE; following 8'h06 gives no ack and no strobe.
- Auto-increment wrap, ai_i=1, pointer 8'd68:
  - Writing 3 bytes gives strobes at 68, 69, 0.
  - With pointer 254, two reads fetch 254 then 255, and the pointer ends at 250.
- ai_i=0: pointer 8'd10, write 8'h11, 8'h22 -> two strobes both at addr 10; final pointer 10.
- Repeated START read, reg_rdata_i modelled, ai_i=1:
  - Sequence: 8'h80, 8'h08, START, 8'h81, tx_req_i twice, nack_i -> tx_byte_o = reg[8] then reg[9].
  - After the NACK the block is in IGNORE; tx_req_i there produces no tx_valid_o.
- Reset and priority:
  - rst_ni=0 asserted during WRITE right after byte_valid_i -> no reg_we_o, all outputs reset, reg_addr_o=0.
  - start_i and byte_valid_i in the same cycle -> ADDR, no write.
